uart_rx: RTL

Asynchronous serial receiver, 8N1, LSB first. Samples the off-chip `uart_rx_i` line with a fixed oversampling counter derived from `CLK_FREQ`/`BAUDRATE`, checks the start and stop bits, and presents each received byte on a valid/ready handshake. A one-entry output register sits between the deserializer and the consumer. Overrun and framing errors are reported as one-cycle pulses. It is the receive-side counterpart of the UART transmitter and sits at the chip boundary, feeding the core-side byte stream.

---
 rtl/uart_rx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized input, mid-bit sampling from a fixed baud
// counter, one-entry valid/ready output register, overrun/framing error pulses.
module uart_rx #(
    parameter logic [31:0] CLK_FREQ = 32'd50_000_000,
    parameter logic [31:0] BAUDRATE = 32'd115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_i,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic [7:0] rx_data_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int unsigned BAUD_CNT_MAX  = CLK_FREQ / BAUDRATE;
    localparam int unsigned BAUD_CNT_HALF = BAUD_CNT_MAX / 2;
    localparam int unsigned CW            = $clog2(BAUD_CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST    = CW'(BAUD_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_MID     = CW'(BAUD_CNT_HALF - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic [1:0]      sync_q;
    logic            prev_q;
    logic            rx_s;
    logic            fall;

    assign rx_s = sync_q[1];
    assign fall = prev_q & ~rx_s;

    // Synchronizer and edge flop reset to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], uart_rx_i};
            prev_q <= sync_q[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        if (valid_q && rx_ready_i) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        // A same-cycle consume frees the register for the new byte.
                        if (!valid_q || rx_ready_i) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_valid_o  = valid_q;
    assign rx_data_o   = data_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule
